// File: rtl/note_pkg.sv
// Shared types and constants for the note-lane spawn scheduler.
package note_pkg;

    localparam int N_SLOTS = 8;
    localparam int CMD_W   = 4;
    localparam int SCORE_W = 16;
    localparam int IDX_W   = $clog2(N_SLOTS);
    localparam int CNT_W   = $clog2(N_SLOTS + 1);

    localparam logic [CMD_W-1:0] CMD_REST = '0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BEAT,
        ALLOC,
        DRAIN,
        DONE
    } state_t;

    function automatic logic [CNT_W-1:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/note_spawn_scheduler_if.sv
// Bundle of list-manager, pattern-slot and score-display signals around the scheduler.
interface note_spawn_scheduler_if;
    import note_pkg::*;

    logic                start;
    logic                frame_tick;
    logic [CMD_W-1:0]    cmd_in;
    logic                list_end;
    logic                cmd_next;
    logic [N_SLOTS-1:0]  slot_busy;
    logic [N_SLOTS-1:0]  slot_load;
    logic [CMD_W-1:0]    slot_cmd;
    logic [N_SLOTS-1:0]  hit_pulse;
    logic [N_SLOTS-1:0]  miss_pulse;
    logic [SCORE_W-1:0]  score;
    logic [7:0]          combo;
    logic                stall;
    logic                game_over;

    modport master (
        output start, frame_tick, cmd_in, list_end, slot_busy, hit_pulse, miss_pulse,
        input  cmd_next, slot_load, slot_cmd, score, combo, stall, game_over
    );

    modport slave (
        input  start, frame_tick, cmd_in, list_end, slot_busy, hit_pulse, miss_pulse,
        output cmd_next, slot_load, slot_cmd, score, combo, stall, game_over
    );

endinterface

// File: rtl/rr_free_picker.sv
// Finds the first idle pattern slot at or after rr_ptr, wrapping modulo N_SLOTS.
module rr_free_picker
    import note_pkg::*;
(
    input  logic [N_SLOTS-1:0] busy,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index,
    output logic [N_SLOTS-1:0] grant
);

    int pos;

    // Walk from the far end back toward rr_ptr so the nearest free slot wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        grant = '0;
        pos   = 0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            pos = int'(rr_ptr) + k;
            if (pos >= N_SLOTS) pos = pos - N_SLOTS;
            if (!busy[IDX_W'(pos)]) begin
                found = 1'b1;
                index = IDX_W'(pos);
            end
        end
        if (found) grant[index] = 1'b1;
    end

endmodule

// File: rtl/note_spawn_scheduler.sv
// Paces command fetches per frame, hands notes to free slots round-robin, keeps score.
//   state     | meaning
//   IDLE      | no game; waiting for start
//   WAIT_BEAT | counting frame ticks until the next fetch
//   ALLOC     | one-cycle dispatch decision; stays here while all slots are busy
//   DRAIN     | list exhausted; waiting for every slot to go idle
//   DONE      | game over; score and combo held until start
module note_spawn_scheduler
    import note_pkg::*;
#(
    parameter int SPAWN_FRAMES = 30
) (
    input  logic                 CLOCK_25,
    input  logic                 reset,
    note_spawn_scheduler_if.slave sched
);

    localparam logic [7:0] LAST_FRAME = 8'(SPAWN_FRAMES - 1);

    state_t              state, state_d;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_d;
    logic [7:0]          frame_cnt;
    logic                clear_game;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [N_SLOTS-1:0]  pick_grant;
    logic [N_SLOTS-1:0]  load_d, load_q;
    logic [CMD_W-1:0]    cmd_d, cmd_q;
    logic                next_d, next_q;
    logic                stall_d, stall_q;
    logic [SCORE_W-1:0]  score_q;
    logic [7:0]          combo_q;
    logic [CNT_W-1:0]    hits;
    logic [SCORE_W:0]    score_sum;
    logic [8:0]          combo_sum;
    logic                scoring;

    rr_free_picker u_picker (
        .busy   (sched.slot_busy),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx),
        .grant  (pick_grant)
    );

    always_ff @(posedge CLOCK_25) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        load_d     = '0;
        cmd_d      = '0;
        next_d     = 1'b0;
        stall_d    = 1'b0;
        clear_game = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (sched.start) begin
                    state_d    = WAIT_BEAT;
                    clear_game = 1'b1;
                end
            end
            WAIT_BEAT: begin
                if (sched.frame_tick && frame_cnt == LAST_FRAME) state_d = ALLOC;
            end
            ALLOC: begin
                if (sched.list_end) begin
                    state_d = DRAIN;
                end else if (sched.cmd_in == CMD_REST) begin
                    next_d  = 1'b1;
                    state_d = WAIT_BEAT;
                end else if (pick_found) begin
                    load_d   = pick_grant;
                    cmd_d    = sched.cmd_in;
                    next_d   = 1'b1;
                    rr_ptr_d = (pick_idx == IDX_W'(N_SLOTS - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d  = WAIT_BEAT;
                end else begin
                    stall_d = 1'b1;
                end
            end
            DRAIN: begin
                if (sched.slot_busy == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign scoring   = (state == WAIT_BEAT) || (state == ALLOC) || (state == DRAIN);
    assign hits      = popcount(sched.hit_pulse);
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(hits);
    assign combo_sum = {1'b0, combo_q} + 9'(hits);

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            rr_ptr    <= '0;
            frame_cnt <= '0;
            load_q    <= '0;
            cmd_q     <= '0;
            next_q    <= 1'b0;
            stall_q   <= 1'b0;
            score_q   <= '0;
            combo_q   <= '0;
        end else begin
            rr_ptr  <= rr_ptr_d;
            load_q  <= load_d;
            cmd_q   <= cmd_d;
            next_q  <= next_d;
            stall_q <= stall_d;
            // Ticks only count in WAIT_BEAT, so leaving ALLOC always restarts the cadence from 0.
            if (clear_game)
                frame_cnt <= '0;
            else if (state == WAIT_BEAT && sched.frame_tick)
                frame_cnt <= (frame_cnt == LAST_FRAME) ? '0 : frame_cnt + 8'd1;
            if (clear_game) begin
                score_q <= '0;
                combo_q <= '0;
            end else if (scoring) begin
                score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                combo_q <= (|sched.miss_pulse) ? 8'(hits)
                         : (combo_sum[8] ? 8'hFF : combo_sum[7:0]);
            end
        end
    end

    assign sched.cmd_next  = next_q;
    assign sched.slot_load = load_q;
    assign sched.slot_cmd  = cmd_q;
    assign sched.score     = score_q;
    assign sched.combo     = combo_q;
    assign sched.stall     = stall_q;
    assign sched.game_over = (state == DONE);

endmodule

// File: tb/tb_note_spawn_scheduler.sv
// Bench for note_spawn_scheduler: strobe scoreboard, scoring vector table, directed corner sequences.
module tb_note_spawn_scheduler;
    import note_pkg::*;

    typedef struct packed {
        logic [7:0] load;
        logic [3:0] cmd;
        logic       nxt;
    } strobe_t;

    typedef struct {
        logic [7:0]  hit;
        logic [7:0]  miss;
        logic [15:0] score;
        logic [7:0]  combo;
    } score_vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         checks   = 0;
    int         failures = 0;
    strobe_t    sb[$];
    strobe_t    mon_got, mon_exp;
    score_vec_t vec[6];

    note_spawn_scheduler_if sif ();

    note_spawn_scheduler #(.SPAWN_FRAMES(2)) dut (
        .CLOCK_25 (clk),
        .reset    (reset),
        .sched    (sif)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat();
        sif.frame_tick = 1'b1;
        step();
        sif.frame_tick = 1'b0;
        step();
    endtask

    // Two beats reach ALLOC; the strobe must be on the outputs right after the decision edge.
    task automatic spawn(input logic [7:0] load, input logic [3:0] cmd);
        strobe_t e;
        e.load = load;
        e.cmd  = cmd;
        e.nxt  = 1'b1;
        sb.push_back(e);
        beat();
        beat();
        @(negedge clk);
        #1;
        check("strobe_latency", sb.size(), 0);
        if (sb.size() != 0) sb.delete();
    endtask

    always @(negedge clk) begin
        if (sif.cmd_next || (|sif.slot_load)) begin
            mon_got = {sif.slot_load, sif.slot_cmd, sif.cmd_next};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe: got load=%h cmd=%h next=%b, expected none",
                         mon_got.load, mon_got.cmd, mon_got.nxt);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL strobe: got load=%h cmd=%h next=%b, expected load=%h cmd=%h next=%b",
                             mon_got.load, mon_got.cmd, mon_got.nxt,
                             mon_exp.load, mon_exp.cmd, mon_exp.nxt);
                end
            end
        end
    end

    initial begin
        strobe_t e;

        vec[0] = '{8'h05, 8'h00, 16'd2,  8'd2};
        vec[1] = '{8'h01, 8'h02, 16'd3,  8'd1};
        vec[2] = '{8'hFF, 8'h00, 16'd11, 8'd9};
        vec[3] = '{8'h00, 8'h80, 16'd11, 8'd0};
        vec[4] = '{8'h0F, 8'h01, 16'd15, 8'd4};
        vec[5] = '{8'h00, 8'h00, 16'd15, 8'd4};

        sif.start      = 1'b0;
        sif.frame_tick = 1'b0;
        sif.cmd_in     = '0;
        sif.list_end   = 1'b0;
        sif.slot_busy  = '0;
        sif.hit_pulse  = '0;
        sif.miss_pulse = '0;

        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        check("rst_score",     sif.score,     0);
        check("rst_combo",     sif.combo,     0);
        check("rst_stall",     sif.stall,     0);
        check("rst_game_over", sif.game_over, 0);
        check("rst_cmd_next",  sif.cmd_next,  0);
        check("rst_slot_load", sif.slot_load, 0);
        check("rst_slot_cmd",  sif.slot_cmd,  0);

        sif.start = 1'b1;
        step();
        sif.start = 1'b0;

        // Round-robin from 0, then a skip over busy slots and a wrap past slot 7.
        sif.cmd_in = 4'h1; spawn(8'h01, 4'h1);
        spawn(8'h02, 4'h1);
        sif.cmd_in = 4'h3; spawn(8'h04, 4'h3);
        sif.slot_busy = 8'h38; sif.cmd_in = 4'h5; spawn(8'h40, 4'h5);
        sif.slot_busy = 8'h80; sif.cmd_in = 4'h6; spawn(8'h01, 4'h6);

        // Rest: cmd_next only, pointer stays on slot 1.
        sif.slot_busy = 8'h00; sif.cmd_in = 4'h0; spawn(8'h00, 4'h0);
        sif.cmd_in = 4'h7; spawn(8'h02, 4'h7);

        // All slots busy: five stall cycles, then slot 2 frees up.
        sif.slot_busy = 8'hFF;
        sif.cmd_in    = 4'h9;
        e.load = 8'h04; e.cmd = 4'h9; e.nxt = 1'b1;
        sb.push_back(e);
        beat();
        sif.frame_tick = 1'b1;
        step();
        sif.frame_tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_high",    sif.stall,     1);
            check("stall_no_load", sif.slot_load, 0);
        end
        sif.slot_busy = 8'hFB;
        step();
        check("stall_release",      sif.stall,     0);
        check("stall_release_load", sif.slot_load, 8'h04);
        @(negedge clk);
        #1;
        check("stall_release_sb", sb.size(), 0);
        if (sb.size() != 0) sb.delete();

        sif.slot_busy = 8'h00;
        sif.cmd_in    = 4'h0;
        for (int i = 0; i < 6; i++) begin
            sif.hit_pulse  = vec[i].hit;
            sif.miss_pulse = vec[i].miss;
            step();
            sif.hit_pulse  = '0;
            sif.miss_pulse = '0;
            check("vec_score", sif.score, vec[i].score);
            check("vec_combo", sif.combo, vec[i].combo);
        end

        // 15 + 8189*8 + 7 lands exactly on 16'hFFFE.
        sif.hit_pulse = 8'hFF;
        repeat (8189) step();
        sif.hit_pulse = 8'h7F;
        step();
        sif.hit_pulse = '0;
        check("score_fffe",     sif.score, 16'hFFFE);
        check("combo_sat",      sif.combo, 8'd255);
        sif.hit_pulse = 8'h07;
        step();
        sif.hit_pulse = '0;
        check("score_sat",      sif.score, 16'hFFFF);
        sif.hit_pulse = 8'hFF;
        step();
        sif.hit_pulse = '0;
        check("score_sat_hold", sif.score, 16'hFFFF);
        sif.miss_pulse = 8'h01;
        step();
        sif.miss_pulse = '0;
        check("miss_clears",    sif.combo, 0);

        // List exhausted with slot 4 still busy.
        sif.list_end  = 1'b1;
        sif.slot_busy = 8'h10;
        sif.cmd_in    = 4'h2;
        beat();
        beat();
        sif.hit_pulse = 8'h01;
        step();
        sif.hit_pulse = '0;
        check("drain_combo", sif.combo, 1);
        check("drain_score", sif.score, 16'hFFFF);
        repeat (9) step();
        check("drain_wait", sif.game_over, 0);
        sif.slot_busy = 8'h00;
        step();
        check("game_over", sif.game_over, 1);

        sif.hit_pulse = 8'hFF;
        step();
        sif.hit_pulse = '0;
        check("done_score_hold", sif.score, 16'hFFFF);
        check("done_combo_hold", sif.combo, 1);

        sif.list_end = 1'b0;
        sif.start    = 1'b1;
        step();
        sif.start    = 1'b0;
        check("restart_game_over", sif.game_over, 0);
        check("restart_score",     sif.score,     0);
        check("restart_combo",     sif.combo,     0);

        // Reset lands on the edge that would register an ALLOC decision.
        sif.cmd_in = 4'h3;
        beat();
        sif.frame_tick = 1'b1;
        sif.hit_pulse  = 8'h03;
        step();
        sif.frame_tick = 1'b0;
        sif.hit_pulse  = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_cmd_next",  sif.cmd_next,  0);
        check("midrst_slot_load", sif.slot_load, 0);
        check("midrst_score",     sif.score,     0);
        check("midrst_stall",     sif.stall,     0);
        check("midrst_game_over", sif.game_over, 0);

        // Back in IDLE: ticks and hits do nothing until start.
        beat();
        beat();
        beat();
        sif.hit_pulse = 8'hFF;
        step();
        sif.hit_pulse = '0;
        check("idle_no_score", sif.score, 0);

        sif.start = 1'b1;
        step();
        sif.start = 1'b0;
        spawn(8'h01, 4'h3);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
